// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// datapath mux selects and the main-control state enum.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_AND   = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_A      = 2'd3;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_RWB      = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_IMMEXEC  = 4'd11,
    S_IMMWB    = 4'd12,
    S_JR       = 4'd13
  } state_t;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Only the state is
// registered; every strobe decodes combinationally so reset clears them at once.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       jump_reg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADDR;
          OP_R:             state_d = jump_reg ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J, OP_JAL:     state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_IMMEXEC;
          default:          state_d = S_FETCH;
        endcase
      end
      // IR is frozen after FETCH, so anything but lw/sw here cannot occur.
      S_MEMADDR:  state_d = (opcode == OP_LW) ? S_MEMREAD :
                            (opcode == OP_SW) ? S_MEMWRITE : S_FETCH;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_RWB;
      S_IMMEXEC:  state_d = S_IMMWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = RDST_RT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCS_ALU;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMMSH;
        illegal_op = !(opcode inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                                      OP_ADDI, OP_ANDI, OP_LW, OP_SW});
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = RDST_RD;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = RDST_RA;
        end
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_IMMWB:    reg_write = 1'b1;
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCS_A;
      end
      default: ;
    endcase
  end

endmodule
